// File: rtl/rtc_display_pkg.sv
// Shared constants and types for the frame-synchronised RTC capture buffer.
package rtc_display_pkg;

  localparam int unsigned N_CLK_FIELDS = 9;
  localparam int unsigned N_TMR_FIELDS = 4;
  localparam int unsigned N_FIELDS     = N_CLK_FIELDS + N_TMR_FIELDS;

  // Field indices; timer fields follow the clock fields.
  typedef enum logic [3:0] {
    F_CENT, F_SEG, F_MIN, F_HORA, F_FECHA, F_MES, F_ANIO, F_DSEM, F_NSEM,
    F_CENT_T, F_SEG_T, F_MIN_T, F_HORA_T
  } field_e;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_ERR   = 7'h3F;

  // Both nibbles are invalid BCD, so a timed-out field renders as "??".
  localparam logic [7:0] TIMEOUT_FILL = 8'hAA;

  typedef enum logic [1:0] {StIdle, StReq, StDone} cap_state_e;

endpackage

// File: rtl/rtc_frame_capture_if.sv
// Request/acknowledge fetch bus between the capture buffer and the RTC register file.
interface rtc_frame_capture_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              rtc_req;
  logic [ADDR_W-1:0] rtc_addr;
  logic              rtc_ack;
  logic [7:0]        rtc_data;

  modport master (output rtc_req, rtc_addr, input rtc_ack, rtc_data);
  modport slave  (input rtc_req, rtc_addr, output rtc_ack, rtc_data);
endinterface

// File: rtl/bcd_to_ascii.sv
// Combinational BCD nibble to ASCII digit; non-decimal nibbles map to '?'.
module bcd_to_ascii
  import rtc_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] ascii
);

  always_comb begin
    ascii = ASCII_ERR;
    if (nibble <= 4'd9) ascii = ASCII_ZERO | {3'b000, nibble};
  end

endmodule

// File: rtl/rtc_frame_capture.sv
// Once-per-frame RTC field capture into a shadow bank, swapped at start of frame.
// Optional cursor/timer blink is enabled by defining RTC_CURSOR_BLINK_EN.
module rtc_frame_capture
  import rtc_display_pkg::*;
#(
  parameter int unsigned H_LAST      = 639,
  parameter int unsigned V_LAST      = 479,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned BLINK_DIV_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                temporizador,
  input  logic                temporizador_fin,
  input  logic [2:0]          cursor,
  rtc_frame_capture_if.master rtc,
  input  logic [ADDR_W-1:0]   rd_field,
  input  logic                rd_digit,
  output logic [6:0]          rd_ascii,
  output logic                frame_valid,
  output logic                capture_busy,
  output logic                rtc_timeout,
  output logic                fin_flag
);

  localparam int unsigned FIELD_W = $clog2(N_FIELDS);
  localparam int unsigned WAIT_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W:0]   N_FIELDS_W = (ADDR_W + 1)'(N_FIELDS);
  localparam logic [ADDR_W:0]   N_CLK_W    = (ADDR_W + 1)'(N_CLK_FIELDS);
  localparam logic [ADDR_W:0]   ONE_W      = (ADDR_W + 1)'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  cap_state_e        state_q;
  logic              req_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W:0]   n_act_q;
  logic [ADDR_W:0]   disp_n_act_q;
  logic              fin_q;
  logic              fin_flag_q;
  logic              busy_q;
  logic              timeout_q;
  logic              frame_valid_q;
  logic              bank_sel_q;
  logic [7:0]        bank_q [2][N_FIELDS];
  logic [6:0]        rd_ascii_q;

  logic               tick;
  logic               sof;
  logic               last_field;
  logic [FIELD_W-1:0] wr_idx;

  assign tick       = (pixel_x == 10'(H_LAST)) && (pixel_y == 10'(V_LAST));
  assign sof        = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign last_field = ({1'b0, idx_q} + ONE_W) == n_act_q;
  assign wr_idx     = FIELD_W'(idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_q         <= 1'b0;
      idx_q         <= '0;
      wait_q        <= '0;
      n_act_q       <= '0;
      disp_n_act_q  <= '0;
      fin_q         <= 1'b0;
      fin_flag_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      bank_sel_q    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int f = 0; f < int'(N_FIELDS); f++) bank_q[b][f] <= 8'h00;
      end
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            n_act_q <= temporizador ? N_FIELDS_W : N_CLK_W;
            fin_q   <= temporizador_fin;
            idx_q   <= '0;
            wait_q  <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (!req_q) begin
            // Gap cycle between fields: re-request the next index.
            req_q <= 1'b1;
          end else if (rtc.rtc_ack || (wait_q == WAIT_LAST)) begin
            bank_q[~bank_sel_q][wr_idx] <= rtc.rtc_ack ? rtc.rtc_data : TIMEOUT_FILL;
            timeout_q <= ~rtc.rtc_ack;
            wait_q    <= '0;
            req_q     <= 1'b0;
            if (last_field) state_q <= StDone;
            else            idx_q   <= idx_q + ADDR_W'(1);
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        StDone: begin
          if (sof) begin
            bank_sel_q    <= ~bank_sel_q;
            disp_n_act_q  <= n_act_q;
            fin_flag_q    <= fin_q;
            frame_valid_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rtc.rtc_req  = req_q;
  assign rtc.rtc_addr = idx_q;

  // Read path: range check, nibble select, ASCII conversion, optional blink.
  logic               in_range;
  logic [FIELD_W-1:0] rd_idx;
  logic [7:0]         rd_byte;
  logic [3:0]         rd_nibble;
  logic [6:0]         conv_ascii;
  logic               blank_blink;

  always_comb begin
    in_range  = frame_valid_q && ({1'b0, rd_field} < disp_n_act_q)
                && ({1'b0, rd_field} < N_FIELDS_W);
    rd_idx    = in_range ? FIELD_W'(rd_field) : '0;
    rd_byte   = bank_q[bank_sel_q][rd_idx];
    rd_nibble = rd_digit ? rd_byte[3:0] : rd_byte[7:4];
  end

  bcd_to_ascii u_bcd_to_ascii (
    .nibble (rd_nibble),
    .ascii  (conv_ascii)
  );

`ifdef RTC_CURSOR_BLINK_EN
  logic                   swap;
  logic [BLINK_DIV_W-1:0] blink_cnt_q;

  assign swap = (state_q == StDone) && sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    blink_cnt_q <= '0;
    else if (swap) blink_cnt_q <= blink_cnt_q + BLINK_DIV_W'(1);
  end

  always_comb begin
    blank_blink = 1'b0;
    if (blink_cnt_q[BLINK_DIV_W-1]) begin
      if (!temporizador_fin && (rd_field == ADDR_W'(cursor))) blank_blink = 1'b1;
      if (fin_flag_q && ({1'b0, rd_field} >= N_CLK_W))        blank_blink = 1'b1;
    end
  end
`else
  localparam int unsigned unused_blink_div_w = BLINK_DIV_W;
  logic unused_cursor;
  assign unused_cursor = ^cursor;
  assign blank_blink   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ascii_q <= ASCII_SPACE;
    else        rd_ascii_q <= (in_range && !blank_blink) ? conv_ascii : ASCII_SPACE;
  end

  assign rd_ascii     = rd_ascii_q;
  assign frame_valid  = frame_valid_q;
  assign capture_busy = busy_q;
  assign rtc_timeout  = timeout_q;
  assign fin_flag     = fin_flag_q;

endmodule

// File: tb/tb_rtc_frame_capture.sv
// Scoreboard bench for rtc_frame_capture: reads push expected codes, a monitor checks them.
module tb_rtc_frame_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixel_x = 10'd100;
  logic [9:0] pixel_y = 10'd100;
  logic       temporizador = 1'b0;
  logic       temporizador_fin = 1'b0;
  logic [2:0] cursor = 3'd1;
  logic [3:0] rd_field = 4'd0;
  logic       rd_digit = 1'b0;
  logic [6:0] rd_ascii;
  logic       frame_valid, capture_busy, rtc_timeout, fin_flag;

  rtc_frame_capture_if #(.ADDR_W(4)) ifc ();

  rtc_frame_capture dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pixel_x          (pixel_x),
    .pixel_y          (pixel_y),
    .temporizador     (temporizador),
    .temporizador_fin (temporizador_fin),
    .cursor           (cursor),
    .rtc              (ifc),
    .rd_field         (rd_field),
    .rd_digit         (rd_digit),
    .rd_ascii         (rd_ascii),
    .frame_valid      (frame_valid),
    .capture_busy     (capture_busy),
    .rtc_timeout      (rtc_timeout),
    .fin_flag         (fin_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RTC register model: acks one cycle after seeing a request, except a chosen field.
  logic [7:0] mem [16];
  int         no_ack_field = -1;
  assign ifc.rtc_data = mem[ifc.rtc_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifc.rtc_ack <= 1'b0;
    else ifc.rtc_ack <= ifc.rtc_req && !ifc.rtc_ack && (int'(ifc.rtc_addr) != no_ack_field);
  end

  int addr_log [$];
  int tmo_cnt = 0;
  int f2_req_cycles = 0;
  always @(posedge clk) begin
    if (ifc.rtc_req && ifc.rtc_ack) addr_log.push_back(int'(ifc.rtc_addr));
    if (rtc_timeout) tmo_cnt++;
    if (ifc.rtc_req && ifc.rtc_addr == 4'd2) f2_req_cycles++;
  end

  // Scoreboard: expected read results, checked one cycle after issue.
  typedef struct {
    string      name;
    logic [6:0] val;
  } exp_t;
  exp_t exp_q [$];
  logic rd_strobe = 1'b0;
  logic rd_vld_q  = 1'b0;

  always @(posedge clk) rd_vld_q <= rd_strobe;

  always @(negedge clk) begin
    if (rd_vld_q) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {25'd0, rd_ascii}, {25'd0, e.val});
      end
    end
  end

  task automatic do_read(input string name, input int field, input bit digit,
                         input logic [6:0] exp);
    exp_t e;
    @(negedge clk);
    rd_field  = 4'(field);
    rd_digit  = digit;
    rd_strobe = 1'b1;
    e.name = name;
    e.val  = exp;
    exp_q.push_back(e);
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic capture(input int unsigned budget);
    @(negedge clk);
    pixel_x = 10'd639;
    pixel_y = 10'd479;
    @(negedge clk);
    pixel_x = 10'd100;
    pixel_y = 10'd100;
    repeat (budget) @(negedge clk);
  endtask

  task automatic start_of_frame();
    @(negedge clk);
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    @(negedge clk);
    pixel_x = 10'd100;
    pixel_y = 10'd100;
  endtask

  task automatic load_pattern();
    for (int n = 0; n < 16; n++) mem[n] = {4'(n), 4'(n)};
  endtask

  task automatic check_addr_seq(input string name, input int exp_seq [$]);
    check({name, "_len"}, addr_log.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < addr_log.size(); i++)
      check(name, addr_log[i], exp_seq[i]);
  endtask

  initial begin
    int seq [$];
    load_pattern();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_rtc_req", ifc.rtc_req, 0);
    check("rst_rtc_addr", ifc.rtc_addr, 0);
    check("rst_rd_ascii", rd_ascii, 32'h20);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_busy", capture_busy, 0);
    check("rst_timeout", rtc_timeout, 0);
    check("rst_fin_flag", fin_flag, 0);

    // Clock-only capture with immediate acks.
    addr_log.delete();
    capture(80);
    check("t1_busy_in_done", capture_busy, 1);
    do_read("t1_pre_sof_blank", 3, 0, 7'h20);
    start_of_frame();
    check("t1_frame_valid", frame_valid, 1);
    check("t1_busy_after_sof", capture_busy, 0);
    seq = {0, 1, 2, 3, 4, 5, 6, 7, 8};
    check_addr_seq("t1_addr_seq", seq);
    do_read("t1_f3_tens", 3, 0, 7'h33);
    do_read("t1_f3_units", 3, 1, 7'h33);
    do_read("t1_f8_units", 8, 1, 7'h38);
    do_read("t1_f0_tens", 0, 0, 7'h30);
    do_read("t1_f10_absent", 10, 0, 7'h20);

    // Timer mode: 13 fields, invalid BCD, timer expiry latched at tick.
    mem[4]  = 8'h1C;
    mem[9]  = 8'h07;
    mem[12] = 8'h59;
    temporizador     = 1'b1;
    temporizador_fin = 1'b1;
    addr_log.delete();
    capture(80);
    temporizador_fin = 1'b0;
    check("t2_fin_before_sof", fin_flag, 0);
    start_of_frame();
    check("t2_fin_after_sof", fin_flag, 1);
    seq = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    check_addr_seq("t2_addr_seq", seq);
    do_read("t2_f12_tens", 12, 0, 7'h35);
    do_read("t2_f12_units", 12, 1, 7'h39);
    do_read("t2_f9_units", 9, 1, 7'h37);
    do_read("t2_f4_tens", 4, 0, 7'h31);
    do_read("t2_f4_units_bad", 4, 1, 7'h3F);
    do_read("t2_f13_oor", 13, 0, 7'h20);
    do_read("t2_f15_oor", 15, 1, 7'h20);

    // Timeout on field 2, later fields still fetched.
    load_pattern();
    temporizador  = 1'b0;
    no_ack_field  = 2;
    tmo_cnt       = 0;
    f2_req_cycles = 0;
    addr_log.delete();
    capture(80);
    start_of_frame();
    check("t3_timeout_pulses", tmo_cnt, 1);
    check("t3_f2_wait_cycles", f2_req_cycles, 15);
    check("t3_fin_cleared", fin_flag, 0);
    seq = {0, 1, 3, 4, 5, 6, 7, 8};
    check_addr_seq("t3_addr_seq", seq);
    do_read("t3_f2_tens_tmo", 2, 0, 7'h3F);
    do_read("t3_f2_units_tmo", 2, 1, 7'h3F);
    do_read("t3_f3_tens", 3, 0, 7'h33);
    do_read("t3_f8_units", 8, 1, 7'h38);
    do_read("t3_f12_timer_off", 12, 0, 7'h20);

    // New data is held in the shadow bank until the next start of frame.
    no_ack_field = -1;
    mem[3] = 8'h47;
    capture(80);
    do_read("t4_f3_old", 3, 0, 7'h33);
    do_read("t4_f2_old", 2, 1, 7'h3F);
    start_of_frame();
    do_read("t4_f3_new_tens", 3, 0, 7'h34);
    do_read("t4_f3_new_units", 3, 1, 7'h37);
    do_read("t4_f2_new", 2, 1, 7'h32);

    // Asynchronous reset while a request is outstanding.
    @(negedge clk);
    pixel_x = 10'd639;
    pixel_y = 10'd479;
    @(negedge clk);
    pixel_x = 10'd100;
    pixel_y = 10'd100;
    begin
      int guard = 0;
      while (!ifc.rtc_req && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("t5_req_seen", ifc.rtc_req, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_async_clear", ifc.rtc_req, 0);
    check("t5_frame_valid_clear", frame_valid, 0);
    check("t5_busy_clear", capture_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read("t5_read_after_rst", 3, 0, 7'h20);

`ifdef RTC_CURSOR_BLINK_EN
    // Cursor field blanks while the frame counter MSB is set.
    load_pattern();
    cursor = 3'd1;
    for (int k = 1; k <= 32; k++) begin
      capture(40);
      start_of_frame();
      do_read("t6_cursor_blink", 1, 1, ((k % 32) >= 16) ? 7'h20 : 7'h31);
    end
    do_read("t6_other_field", 0, 1, 7'h30);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
